branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Micro-step sequencer for conditional-branch instructions (brzr, brnz, brpl, brmi). The control unit hands it the execute phase of a decoded branch once T0–T2 fetch/decode is complete. It drives the datapath strobes for T3–T6 and latches the branch condition into the CON flip-flop. It then loads the PC with the branch target only if the CON flip-flop output is 1. It also keeps saturating taken/not-taken counters for debug.

## Interface
Parameters:
- CNT_W, 16, width of each branch statistics counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
- start  in  1  control unit request to run a branch execute phase; sampled only in IDLE
- hold  in  1  stall (memory/bus wait); freezes state, strobes forced low
- con  in  1  q output of the CON flip-flop
- clear_cnt  in  1  synchronous clear of both counters
- Gra  out  1  select Ra field of IR as register-file address
- Rout  out  1  drive selected register onto bus
- CONin  out  1  load enable for the CON flip-flop
- PCout  out  1  drive PC onto bus
- Yin  out  1  load Y register
- Cout  out  1  drive sign-extended C immediate onto bus
- alu_add  out  1  ALU operation select = ADD
- Zin  out  1  load Z register
- Zlowout  out  1  drive Z[31:0] onto bus
- PCin  out  1  load PC from bus
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse in T6
- taken_cnt  out  CNT_W  number of completed branches with con=1
- not_taken_cnt  out  CNT_W  number of completed branches with con=0

## Operation
- States: IDLE, T3, T4, T5, T6, encoded in a registered state variable.
- Strobes are Moore outputs decoded from state. PCin is the exception: it also depends on con. All strobes are 0 when hold=1.
- Strobes asserted per state:
  - IDLE: none.
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, alu_add, Zin.
  - T6: Zlowout, PCin = con, done.
- State transitions:
  - IDLE→T3 when start=1.
  - T3→T4→T5→T6→IDLE, one state per cycle while hold=0.
  - Any state with hold=1 stays in the same state.
- start is ignored while busy=1; no queuing.
- Counters update at the end of T6 when hold=0. taken_cnt increments if con=1; otherwise not_taken_cnt increments.
- Each counter saturates at all-ones and never wraps.
- clear_cnt=1 zeroes both counters. clear_cnt has priority over a same-cycle increment.
- Reset values: state IDLE; all strobes, busy and done 0; both counters 0.

## Timing
- Cycle 0: start=1 in IDLE. Cycle 1: T3. Cycle 4: T6 with done=1. Cycle 5: IDLE, so a new start is accepted in cycle 5.
- Minimum execute latency is 4 cycles from the start acceptance edge to the PC update edge. Each hold cycle adds 1.
- CONin is high in T3. The CON flip-flop captures the condition on the T3→T4 edge, so con is valid from T4 onward.
- The sequencer reads con only in T6; values of con in T3 are don't-care.
- hold asserted in T6 suppresses PCin, done and the counter update. All three occur on the first T6 cycle that has hold=0.
- Reset asserted mid-sequence drops all outputs immediately (asynchronous) and leaves the PC unchanged unless the PCin edge has already occurred. After reset deassertion the block is in IDLE and accepts start on the next edge.
- start and hold high in the same IDLE cycle: remain in IDLE; start must be re-presented.

## Test plan
- Taken branch: start pulse, con=1 from T4 → strobes T3{Gra,Rout,CONin}, T4{PCout,Yin}, T5{Cout,alu_add,Zin}, T6{Zlowout,PCin,done}; taken_cnt 0→1; busy high for exactly 4 cycles.
- Not-taken branch: same sequence with con=0 → PCin stays 0 in T6, done=1, not_taken_cnt 0→1, taken_cnt unchanged.
- Hold: hold=1 for 2 cycles in T5, then for 1 cycle in T6 → state frozen, all strobes 0 during hold; Zin asserted once when released; done and the counter update occur in the single T6 cycle with hold=0; total busy = 7 cycles.
- Back-to-back and ignored start: start held high continuously → sequences restart every 5 cycles; start pulses during T4 have no effect.
- Saturation and clear, with CNT_W=4:
  - 16 taken branches → taken_cnt stays 4'hF.
  - clear_cnt coincident with a T6 update → both counters 0.
- Reset mid-operation: assert reset in T5 → all outputs 0 within the same cycle, counters 0; after release, start gives T3 on the next cycle.

Source files
------------

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - execute-phase micro-step sequencer for conditional branches
//
// Purpose:
//   Drives the datapath strobes for steps T3..T6 of brzr/brnz/brpl/brmi once
//   fetch/decode has finished. The CON flip-flop is loaded in T3. The PC is
//   loaded in T6 only when that flip-flop reads 1. The block also keeps
//   saturating taken/not-taken counters for debug.
//
// Ports:
//   clk            in   system clock, rising-edge
//   reset          in   asynchronous active-high reset
//   start          in   run a branch execute phase (sampled only in IDLE)
//   hold           in   stall: freeze state, force strobes low
//   con            in   q output of the CON flip-flop
//   clear_cnt      in   synchronous clear of both counters
//   Gra..PCin      out  datapath strobes
//   busy           out  high outside IDLE
//   done           out  one-cycle pulse in the completing T6 cycle
//   taken_cnt      out  completed branches with con=1 (saturating)
//   not_taken_cnt  out  completed branches with con=0 (saturating)

module branch_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic             con,
  input  logic             clear_cnt,
  output logic             Gra,
  output logic             Rout,
  output logic             CONin,
  output logic             PCout,
  output logic             Yin,
  output logic             Cout,
  output logic             alu_add,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T3   = 3'd1,
    S_T4   = 3'd2,
    S_T5   = 3'd3,
    S_T6   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] not_taken_q, not_taken_d;
  logic             cnt_upd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      taken_q     <= '0;
      not_taken_q <= '0;
    end else begin
      state_q     <= state_d;
      taken_q     <= taken_d;
      not_taken_q <= not_taken_d;
    end
  end

  // Every non-idle state advances only on a hold-free cycle, and its strobes
  // are gated by the same condition so a stalled step never half-executes.
  always_comb begin
    state_d = state_q;
    Gra     = 1'b0;
    Rout    = 1'b0;
    CONin   = 1'b0;
    PCout   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    alu_add = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // start coincident with hold is dropped, not remembered.
        if (start && !hold) state_d = S_T3;
      end
      S_T3: begin
        if (!hold) begin
          Gra     = 1'b1;
          Rout    = 1'b1;
          CONin   = 1'b1;
          state_d = S_T4;
        end
      end
      S_T4: begin
        if (!hold) begin
          PCout   = 1'b1;
          Yin     = 1'b1;
          state_d = S_T5;
        end
      end
      S_T5: begin
        if (!hold) begin
          Cout    = 1'b1;
          alu_add = 1'b1;
          Zin     = 1'b1;
          state_d = S_T6;
        end
      end
      S_T6: begin
        if (!hold) begin
          Zlowout = 1'b1;
          PCin    = con;
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign cnt_upd = (state_q == S_T6) && !hold;

  // A clear wins over a same-cycle completion; counters stick at all-ones.
  always_comb begin
    taken_d     = taken_q;
    not_taken_d = not_taken_q;
    if (clear_cnt) begin
      taken_d     = '0;
      not_taken_d = '0;
    end else if (cnt_upd) begin
      if (con) begin
        if (taken_q != CNT_MAX) taken_d = taken_q + 1'b1;
      end else begin
        if (not_taken_q != CNT_MAX) not_taken_d = not_taken_q + 1'b1;
      end
    end
  end

  assign taken_cnt     = taken_q;
  assign not_taken_cnt = not_taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - self-checking bench for branch_sequencer

module tb_branch_sequencer;

  localparam int W    = 4;
  localparam int SMAX = 15;

  logic         clk, reset, start, hold, con, clear_cnt;
  logic         Gra, Rout, CONin, PCout, Yin, Cout, alu_add, Zin, Zlowout, PCin, busy, done;
  logic [W-1:0] taken_cnt, not_taken_cnt;

  branch_sequencer #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .con(con),
    .clear_cnt(clear_cnt), .Gra(Gra), .Rout(Rout), .CONin(CONin),
    .PCout(PCout), .Yin(Yin), .Cout(Cout), .alu_add(alu_add), .Zin(Zin),
    .Zlowout(Zlowout), .PCin(PCin), .busy(busy), .done(done),
    .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Output vector: {Gra,Rout,CONin,PCout,Yin,Cout,alu_add,Zin,Zlowout,PCin,busy,done}
  function automatic logic [11:0] act_vec();
    return {Gra, Rout, CONin, PCout, Yin, Cout, alu_add, Zin, Zlowout, PCin, busy, done};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: phase number 0 (idle) or 3..6, plus integer counters.
  int m_step = 0;
  int m_tk   = 0;
  int m_nt   = 0;

  function automatic logic [11:0] model_out(input int step, input logic h, input logic c);
    logic [11:0] v;
    v = '0;
    if (step != 0) v[1] = 1'b1;
    if (!h) begin
      if (step == 3) v[11:9] = 3'b111;
      if (step == 4) v[8:7]  = 2'b11;
      if (step == 5) v[6:4]  = 3'b111;
      if (step == 6) begin v[3] = 1'b1; v[2] = c; v[0] = 1'b1; end
    end
    return v;
  endfunction

  logic [11:0] a_vec, m_vec;
  int          a_tk, a_nt, e_tk, e_nt;

  // One clock: drive after the edge, sample at the falling edge, advance model.
  task automatic tick(input logic s, input logic h, input logic c, input logic clr);
    start = s; hold = h; con = c; clear_cnt = clr;
    @(negedge clk);
    a_vec = act_vec();
    a_tk  = int'(taken_cnt);
    a_nt  = int'(not_taken_cnt);
    m_vec = model_out(m_step, h, c);
    e_tk  = m_tk;
    e_nt  = m_nt;
    @(posedge clk);
    if (clr) begin
      m_tk = 0; m_nt = 0;
    end else if (m_step == 6 && !h) begin
      if (c) m_tk = (m_tk + 1 > SMAX) ? SMAX : m_tk + 1;
      else   m_nt = (m_nt + 1 > SMAX) ? SMAX : m_nt + 1;
    end
    if (m_step == 0) begin
      if (s && !h) m_step = 3;
    end else if (!h) begin
      m_step = (m_step == 6) ? 0 : m_step + 1;
    end
    #1;
  endtask

  task automatic tick_model(input logic s, input logic h, input logic c, input logic clr, input string name);
    tick(s, h, c, clr);
    chk({name, " strobes"}, int'(a_vec), int'(m_vec));
    chk({name, " counters"}, (a_tk << 8) | a_nt, (e_tk << 8) | e_nt);
  endtask

  typedef struct {
    logic        s, h, c, clr;
    logic [11:0] ev;
    int          tk, nt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic h, input logic c, input logic clr,
                     input logic [11:0] ev, input int tk, input int nt);
    vec_t v;
    v.s = s; v.h = h; v.c = c; v.clr = clr; v.ev = ev; v.tk = tk; v.nt = nt;
    vecs.push_back(v);
  endtask

  localparam logic [11:0] V_ID  = 12'b000000000000;
  localparam logic [11:0] V_T3  = 12'b111000000010;
  localparam logic [11:0] V_T4  = 12'b000110000010;
  localparam logic [11:0] V_T5  = 12'b000001110010;
  localparam logic [11:0] V_T6T = 12'b000000001111;
  localparam logic [11:0] V_T6N = 12'b000000001011;
  localparam logic [11:0] V_HLD = 12'b000000000010;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; con = 1'b0; clear_cnt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset strobes", int'(act_vec()), 0);
    chk("reset counters", int'({taken_cnt, not_taken_cnt}), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // taken branch
    add(0,0,0,0, V_ID, 0,0);  add(1,0,0,0, V_ID, 0,0);
    add(0,0,0,0, V_T3, 0,0);  add(0,0,1,0, V_T4, 0,0);
    add(0,0,1,0, V_T5, 0,0);  add(0,0,1,0, V_T6T,0,0);
    add(0,0,0,0, V_ID, 1,0);
    // not-taken branch
    add(1,0,0,0, V_ID, 1,0);  add(0,0,0,0, V_T3, 1,0);
    add(0,0,0,0, V_T4, 1,0);  add(0,0,0,0, V_T5, 1,0);
    add(0,0,0,0, V_T6N,1,0);  add(0,0,0,0, V_ID, 1,1);
    // hold 2 cycles in T5, 1 cycle in T6
    add(1,0,0,0, V_ID, 1,1);  add(0,0,0,0, V_T3, 1,1);
    add(0,0,1,0, V_T4, 1,1);  add(0,1,1,0, V_HLD,1,1);
    add(0,1,1,0, V_HLD,1,1);  add(0,0,1,0, V_T5, 1,1);
    add(0,1,1,0, V_HLD,1,1);  add(0,0,1,0, V_T6T,1,1);
    add(0,0,0,0, V_ID, 2,1);
    // start with hold in IDLE is dropped
    add(1,1,0,0, V_ID, 2,1);  add(0,0,0,0, V_ID, 2,1);
    // start pulses during the sequence are ignored
    add(1,0,0,0, V_ID, 2,1);  add(0,0,0,0, V_T3, 2,1);
    add(1,0,0,0, V_T4, 2,1);  add(1,0,0,0, V_T5, 2,1);
    add(0,0,0,0, V_T6N,2,1);  add(0,0,0,0, V_ID, 2,2);
    // clear coincident with T6 update
    add(1,0,0,0, V_ID, 2,2);  add(0,0,0,0, V_T3, 2,2);
    add(0,0,1,0, V_T4, 2,2);  add(0,0,1,0, V_T5, 2,2);
    add(0,0,1,1, V_T6T,2,2);  add(0,0,0,0, V_ID, 0,0);
    // start held high: restart every 5 cycles
    add(1,0,0,0, V_ID, 0,0);  add(1,0,0,0, V_T3, 0,0);
    add(1,0,1,0, V_T4, 0,0);  add(1,0,1,0, V_T5, 0,0);
    add(1,0,1,0, V_T6T,0,0);  add(1,0,1,0, V_ID, 1,0);
    add(0,0,1,0, V_T3, 1,0);  add(0,0,1,0, V_T4, 1,0);
    add(0,0,1,0, V_T5, 1,0);  add(0,0,1,0, V_T6T,1,0);
    add(0,0,0,0, V_ID, 2,0);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].s, vecs[i].h, vecs[i].c, vecs[i].clr);
      chk($sformatf("vec%0d strobes", i), int'(a_vec), int'(vecs[i].ev));
      chk($sformatf("vec%0d counters", i), (a_tk << 8) | a_nt, (vecs[i].tk << 8) | vecs[i].nt);
    end

    // saturation: clear then 17 taken branches
    tick_model(0,0,0,1, "sat clr");
    for (int b = 0; b < 17; b++) begin
      tick_model(1,0,0,0, "sat start");
      tick_model(0,0,0,0, "sat t3");
      tick_model(0,0,1,0, "sat t4");
      tick_model(0,0,1,0, "sat t5");
      tick_model(0,0,1,0, "sat t6");
      if (b == 14) chk("taken at 15", int'(taken_cnt), 15);
    end
    chk("taken saturated", int'(taken_cnt), 15);
    chk("not_taken after sat", int'(not_taken_cnt), 0);

    // reset in T5: outputs drop before the next edge
    tick(1,0,0,0); tick(0,0,0,0); tick(0,0,1,0);
    #2 reset = 1'b1;
    #1;
    chk("async reset strobes", int'(act_vec()), 0);
    chk("async reset counters", int'({taken_cnt, not_taken_cnt}), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_step = 0; m_tk = 0; m_nt = 0;
    tick(1,0,0,0);
    chk("post-reset idle", int'(a_vec), int'(V_ID));
    tick(0,0,0,0);
    chk("post-reset T3", int'(a_vec), int'(V_T3));
    tick_model(0,0,0,0, "post-reset t4");

    // randomized against the model
    for (int r = 0; r < 600; r++) begin
      logic rs, rh, rc, rclr;
      rs   = ($urandom_range(0, 1) == 1);
      rh   = ($urandom_range(0, 3) == 0);
      rc   = ($urandom_range(0, 1) == 1);
      rclr = ($urandom_range(0, 39) == 0);
      tick_model(rs, rh, rc, rclr, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
